// File: rtl/mem_pkg.sv
// Shared memory-subsystem types and widths used by the cache controller, cache array and
// main memory.
package mem_pkg;

  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned WORDS_PER_BLOCK = 4;

  localparam int unsigned TAG_W    = 3;
  localparam int unsigned INDEX_W  = 5;
  localparam int unsigned OFFSET_W = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRdWait = 2'b01,
    StWrWait = 2'b10,
    StDone   = 2'b11
  } mem_state_e;

endpackage

// File: rtl/mem_array_1kx32.sv
// Word-addressed backing store: one synchronous write port and a registered, block-aligned
// read port; both act on the falling edge.
module mem_array_1kx32 #(
  parameter int unsigned ADDR_W          = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W          = mem_pkg::DATA_W,
  parameter int unsigned WORDS_PER_BLOCK = mem_pkg::WORDS_PER_BLOCK,
  localparam int unsigned OffsetW        = $clog2(WORDS_PER_BLOCK),
  localparam int unsigned BlkW           = ADDR_W - OffsetW
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              we_i,
  input  logic [ADDR_W-1:0]                 waddr_i,
  input  logic [DATA_W-1:0]                 wdata_i,
  input  logic                              rd_en_i,
  input  logic [BlkW-1:0]                   rd_blk_i,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0] rd_block_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0]                 mem_q [Depth];
  logic [DATA_W*WORDS_PER_BLOCK-1:0] rd_block_q;

  // The array itself has no reset so it can be preloaded and survives controller resets.
  always_ff @(negedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_block_q <= '0;
    end else if (rd_en_i) begin
      for (int w = 0; w < int'(WORDS_PER_BLOCK); w++) begin
        rd_block_q[w*DATA_W +: DATA_W] <= mem_q[{rd_blk_i, OffsetW'(w)}];
      end
    end
  end

  assign rd_block_o = rd_block_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory model behind the cache controller: fixed-latency block reads and word writes,
// completion signalled by a one-cycle ready pulse. All state changes on the falling edge.
module main_memory_ctrl #(
  parameter int unsigned ADDR_W          = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W          = mem_pkg::DATA_W,
  parameter int unsigned WORDS_PER_BLOCK = mem_pkg::WORDS_PER_BLOCK,
  parameter int unsigned LATENCY         = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              mem_read,
  input  logic                              mem_write,
  input  logic [ADDR_W-1:0]                 word_addr,
  input  logic [DATA_W-1:0]                 write_data,
  output logic                              ready,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0] read_block,
  output logic                              busy
);
  import mem_pkg::*;

  localparam int unsigned OffsetW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned BlkW    = ADDR_W - OffsetW;
  localparam int unsigned CntW    = $clog2(LATENCY + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  mem_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [BlkW-1:0]   blk_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              ready_q;
  logic              busy_q;

  logic cnt_zero;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      blk_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Simultaneous read and write is illegal and simply ignored.
          if (mem_read && !mem_write) begin
            blk_q   <= word_addr[ADDR_W-1:OffsetW];
            cnt_q   <= CntInit;
            busy_q  <= 1'b1;
            state_q <= StRdWait;
          end else if (mem_write && !mem_read) begin
            addr_q  <= word_addr;
            data_q  <= write_data;
            cnt_q   <= CntInit;
            busy_q  <= 1'b1;
            state_q <= StWrWait;
          end
        end
        StRdWait, StWrWait: begin
          if (cnt_zero) begin
            ready_q <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array access happens on the final wait edge, so a write commits before its DONE cycle.
  logic arr_we;
  logic arr_rd_en;
  assign arr_we    = (state_q == StWrWait) && cnt_zero;
  assign arr_rd_en = (state_q == StRdWait) && cnt_zero;

  mem_array_1kx32 #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
  ) u_array (
    .clk_i     (clk),
    .rst_ni    (reset),
    .we_i      (arr_we),
    .waddr_i   (addr_q),
    .wdata_i   (data_q),
    .rd_en_i   (arr_rd_en),
    .rd_blk_i  (blk_q),
    .rd_block_o(read_block)
  );

  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl: one instance at LATENCY=4, one at LATENCY=1.
module tb_main_memory_ctrl;

  logic         clk;
  logic         reset;
  logic         mem_read, mem_write;
  logic [9:0]   word_addr;
  logic [31:0]  write_data;
  logic         ready, busy;
  logic [127:0] read_block;

  logic         rd1, wr1;
  logic [9:0]   addr1;
  logic [31:0]  wdata1;
  logic         ready1, busy1;
  logic [127:0] block1;

  int n_vec = 0;
  int n_err = 0;

  main_memory_ctrl #(.LATENCY(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .word_addr (word_addr),
    .write_data(write_data),
    .ready     (ready),
    .read_block(read_block),
    .busy      (busy)
  );

  main_memory_ctrl #(.LATENCY(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (rd1),
    .mem_write (wr1),
    .word_addr (addr1),
    .write_data(wdata1),
    .ready     (ready1),
    .read_block(block1),
    .busy      (busy1)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request for one falling edge, then drop it.
  task automatic start_req(input logic rd, input logic wr, input logic [9:0] a,
                           input logic [31:0] d);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; word_addr = a; write_data = d;
    @(negedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Cycles after the accept edge until ready is seen; 0 on timeout.
  task automatic wait_ready(input string tag, output int lat);
    lat = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); @(posedge clk); #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    int lat;
    start_req(1'b0, 1'b1, a, d);
    wait_ready("wr", lat);
  endtask

  task automatic do_read(input logic [9:0] a, output int lat);
    start_req(1'b1, 1'b0, a, 32'h0);
    wait_ready("rd", lat);
  endtask

  initial begin
    int lat;
    int pulses;
    mem_read = 0; mem_write = 0; word_addr = '0; write_data = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;

    // Reset values
    reset = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check("rst_ready", ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_block", read_block, 128'h0);
    reset = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_block", read_block, 128'h0);

    // Preload
    do_write(10'h100, 32'hA0);
    do_write(10'h101, 32'hA1);
    do_write(10'h102, 32'hA2);
    do_write(10'h103, 32'hA3);
    do_write(10'h3FC, 32'h11);
    do_write(10'h3FD, 32'h22);
    do_write(10'h3FE, 32'h33);
    do_write(10'h3FF, 32'h44);
    do_write(10'h010, 32'h12345678);

    // Block read with latency and single-cycle ready
    start_req(1'b1, 1'b0, 10'h102, 32'h0);
    @(posedge clk); #1;
    check("rd_busy_wait", busy, 1'b1);
    check("rd_ready_wait", ready, 1'b0);
    lat = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(posedge clk);
      if (k > 1) #1;
      if (k > 1 && ready) begin
        lat = k - 1;
        break;
      end
      @(negedge clk);
    end
    // Loop above samples after each edge; recompute cleanly with the helper for the next reads.
    check("rd_latency", lat, 4);
    check("rd_busy_done", busy, 1'b1);
    check("rd_block", read_block, 128'h000000A3_000000A2_000000A1_000000A0);
    @(negedge clk); @(posedge clk); #1;
    check("rd_ready_one_cycle", ready, 1'b0);
    check("rd_idle_busy", busy, 1'b0);

    // Write then read same block at the top of memory
    do_write(10'h3FF, 32'hDEADBEEF);
    check("wr_no_block_update", read_block, 128'h000000A3_000000A2_000000A1_000000A0);
    do_read(10'h3FC, lat);
    check("wr_rd_latency", lat, 4);
    check("wr_rd_block", read_block, 128'hDEADBEEF_00000033_00000022_00000011);

    // Both requests high: ignored
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b1; word_addr = 10'h100;
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); @(posedge clk); #1;
      check("both_busy", busy, 1'b0);
      if (ready) pulses++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (4) begin
      @(negedge clk); @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("both_no_ready", pulses, 0);

    // Address changes during RD_WAIT have no effect
    start_req(1'b1, 1'b0, 10'h101, 32'h0);
    word_addr = 10'h3FD;
    @(posedge clk); #1 word_addr = 10'h010;
    wait_ready("rd_toggle", lat);
    check("toggle_block", read_block, 128'h000000A3_000000A2_000000A1_000000A0);

    // Reset two cycles into a write
    start_req(1'b0, 1'b1, 10'h010, 32'h0BAD0BAD);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    check("midwr_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("midwr_rst_busy", busy, 1'b0);
    @(negedge clk); @(posedge clk); #1;
    reset = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk); @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("midwr_no_ready", pulses, 0);
    do_read(10'h012, lat);
    check("midwr_word", read_block[31:0], 32'h12345678);

    // LATENCY=1 with a held read request
    @(posedge clk); #1;
    wr1 = 1'b1; addr1 = 10'h081; wdata1 = 32'h77;
    @(negedge clk); #1 wr1 = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rd1 = 1'b1; addr1 = 10'h080;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); @(posedge clk); #1;
      check($sformatf("held_ready_%0d", k), ready1, (k % 3) == 1);
      check($sformatf("held_busy_%0d", k), busy1, (k % 3) != 2);
      if (k % 3 == 1) check($sformatf("held_word1_%0d", k), block1[63:32], 32'h77);
    end
    rd1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
Multi-cycle backing data memory directly downstream of the cache controller in the RISC-V-with-cache core. It accepts the controller's read-miss and write-through requests and models main-memory latency with a counter. Completion is signalled with a one-cycle ready pulse. Read misses return a full 4-word block for cache refill; writes update a single word.

Parameters:
ADDR_W, 10, word-address width (1024 words)
DATA_W, 32, word width
WORDS_PER_BLOCK, 4, block size in words; must match the cache line size
LATENCY, 4, cycles from request acceptance to ready; legal range is >= 1

Ports:
clk  input  1  clock; all sequential logic on the falling edge, matching the cache controller
reset  input  1  reset, asynchronous, active-low
mem_read  input  1  read-block request (cache MemoryRead)
mem_write  input  1  write-word request (cache MemoryWrite)
word_addr  input  ADDR_W  word address of the request
write_data  input  DATA_W  store data for writes
ready  output  1  one-cycle completion pulse (to cache controller ready)
read_block  output  DATA_W*WORDS_PER_BLOCK  refill block; word 0 is in [31:0]
busy  output  1  high while a transaction is outstanding (debug/perf)

Behaviour:
- Reset values: ready=0, busy=0, read_block=0, state=IDLE, counter=0. The memory array is not cleared; it may be preloaded from a hex file in simulation.
- Reset asserted mid-transaction: abort immediately. No array write occurs, and no ready pulse is produced after reset is released.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE, at each falling edge:
  - mem_read=1, mem_write=0: latch word_addr[ADDR_W-1:2] as block address, counter=LATENCY-1, go to RD_WAIT.
  - mem_write=1, mem_read=0: latch word_addr and write_data, counter=LATENCY-1, go to WR_WAIT.
  - Both high or both low: stay in IDLE. Both high is illegal and is ignored.
- RD_WAIT / WR_WAIT:
  - Counter decrements each falling edge.
  - At the edge where counter==0, go to DONE.
  - WR_WAIT only: the array word is written at that same edge.
  - RD_WAIT only: read_block is loaded at that same edge with words {blk,00}..{blk,11}.
  - Inputs are ignored while waiting. The request is captured at acceptance, so input changes have no effect.
- DONE:
  - ready=1 for exactly this one cycle, then return to IDLE unconditionally.
  - A request still held high when IDLE is next sampled starts a new transaction. A repeated read is harmless; a repeated write rewrites the same data.
- Latency: accept at edge N; ready is high between edges N+LATENCY and N+LATENCY+1. With LATENCY=1, ready is high in the cycle right after acceptance.
- busy=1 in RD_WAIT, WR_WAIT and DONE; 0 in IDLE.
- read_block holds its value until the next read completes. Writes do not update read_block.
- Write-then-read to the same block: the read returns post-write data, because the write commits before DONE.
- Address wrap: block 0xFF covers words 0x3FC–0x3FF; there is no carry across the block boundary.
- Counter width: $clog2(LATENCY+1).

Decomposition:
- Shared package (mem_pkg):
  - state enum (IDLE=2'b00, RD_WAIT=2'b01, WR_WAIT=2'b10, DONE=2'b11)
  - ADDR_W, DATA_W, WORDS_PER_BLOCK
  - TAG_W=3, INDEX_W=5, OFFSET_W=2, shared with the cache controller and cache array
- Sub-module: mem_array_1kx32. One synchronous write port and a 4-word aligned block read port, clocked on the falling edge.

Test Plan:
- Reset values: hold reset=0 for 3 cycles, then release -> ready=0, busy=0, read_block=0.
- Block read: preload words 0x100..0x103 = 0xA0,0xA1,0xA2,0xA3; pulse mem_read with word_addr=0x102 (LATENCY=4) -> ready high exactly 4 cycles after acceptance, for 1 cycle; read_block=0x000000A3_000000A2_000000A1_000000A0.
- Write then read: mem_write with word_addr=0x3FF, write_data=0xDEADBEEF; after ready, mem_read with 0x3FC -> read_block[127:96]=0xDEADBEEF; words 0x3FC..0x3FE unchanged.
- Illegal and ignored inputs:
  - mem_read=mem_write=1 for 2 cycles -> stays in IDLE, no ready.
  - Toggling word_addr during RD_WAIT -> returned block is the one for the latched address.
- Reset mid-write: assert reset 2 cycles into WR_WAIT for word 0x010 -> no ready pulse after release; word 0x010 retains its old value.
- Held request and minimum latency: keep mem_read high continuously with LATENCY=1 -> ready pulses every 3rd cycle (accept, DONE, IDLE re-accept); same block each time; busy deasserts only in IDLE cycles.
